sccb_target: RTL and testbench

//  SCCB responder (camera-side end of the sccb_if link). Decodes 3-phase write and 2-phase-write + 2-phase-read

---
 rtl/sccb_target.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_sccb_target.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sccb_target.sv
// sccb_target: SCCB responder (camera side of the control link).
// Oversamples scl/sda with ila_clk, decodes START/STOP and byte traffic,
// ACKs its own device ID, and serves an 8-bit register file for 3-phase
// writes and 2-phase-write + 2-phase-read sequences.
// Every committed data byte is reported on wr_stb/wr_addr/wr_data.
module sccb_target #(
    parameter logic [6:0] DEV_ID    = 7'h21,
    parameter int         REG_AW    = 8,
    parameter bit         DRIVE_ACK = 1'b1
) (
    input  logic       ila_clk,
    input  logic       n_rst,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic       wr_stb,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy
);

    localparam int DEPTH = 2 ** REG_AW;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ID,
        S_ID_ACK,
        S_SUB,
        S_SUB_ACK,
        S_WDATA,
        S_WDATA_ACK,
        S_RDATA,
        S_RDATA_ACK,
        S_IGNORE
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronisers and edge/condition detection
    // ------------------------------------------------------------------
    logic [1:0] scl_sync;
    logic [1:0] sda_sync;
    logic       scl_d;
    logic       sda_d;
    logic       scl_s;
    logic       sda_s;

    // Two-flop synchronisers plus one delayed copy; reset to the idle bus level
    // so that leaving reset on a quiet bus never looks like a START or STOP.
    always_ff @(posedge ila_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value of its inputs, independent of statement order.
        if (!n_rst) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], scl_i};
            sda_sync <= {sda_sync[0], sda_i};
            scl_d    <= scl_sync[1];
            sda_d    <= sda_sync[1];
        end
    end

    assign scl_s = scl_sync[1];
    assign sda_s = sda_sync[1];

    logic scl_rise;
    logic scl_fall;
    logic start_cond;
    logic stop_cond;

    assign scl_rise   =  scl_s & ~scl_d;
    assign scl_fall   = ~scl_s &  scl_d;
    assign start_cond =  scl_s &  scl_d &  sda_d & ~sda_s;
    assign stop_cond  =  scl_s &  scl_d & ~sda_d &  sda_s;

    // ------------------------------------------------------------------
    // Protocol state and register file
    // ------------------------------------------------------------------
    state_t              state,     state_n;
    logic [2:0]          bit_cnt,   bit_cnt_n;
    logic [6:0]          shift,     shift_n;
    logic [7:0]          rd_shift,  rd_shift_n;
    logic                rw,        rw_n;
    logic                ack_phase, ack_phase_n;
    logic [REG_AW-1:0]   sub_ptr,   sub_ptr_n;
    logic                sda_oe_n;
    logic                busy_n;
    logic                wr_stb_n;
    logic [7:0]          wr_addr_n;
    logic [7:0]          wr_data_n;
    logic                mem_we;

    logic [7:0]          mem [DEPTH];
    logic [7:0]          rx_byte;
    logic [7:0]          reg_rd;

    // Byte completed by the current scl rise (valid when bit_cnt == 7).
    assign rx_byte = {shift, sda_s};
    assign reg_rd  = mem[sub_ptr];

    // State register and all registered outputs.
    always_ff @(posedge ila_clk) begin
        if (!n_rst) begin
            state     <= S_IDLE;
            bit_cnt   <= '0;
            shift     <= '0;
            rd_shift  <= '0;
            rw        <= 1'b0;
            ack_phase <= 1'b0;
            sub_ptr   <= '0;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            wr_stb    <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            state     <= state_n;
            bit_cnt   <= bit_cnt_n;
            shift     <= shift_n;
            rd_shift  <= rd_shift_n;
            rw        <= rw_n;
            ack_phase <= ack_phase_n;
            sub_ptr   <= sub_ptr_n;
            sda_oe    <= sda_oe_n;
            busy      <= busy_n;
            wr_stb    <= wr_stb_n;
            wr_addr   <= wr_addr_n;
            wr_data   <= wr_data_n;
        end
    end

    // Register file: cleared by reset, written by a completed WDATA byte.
    always_ff @(posedge ila_clk) begin
        // NOTE: the register file has a defined reset value, so it is cleared
        // entry by entry here; this keeps it in flops rather than block RAM.
        if (!n_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (mem_we) begin
            mem[sub_ptr] <= rx_byte;
        end
    end

    // Next-state and next-output logic; START/STOP override bit handling.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_n     = state;
        bit_cnt_n   = bit_cnt;
        shift_n     = shift;
        rd_shift_n  = rd_shift;
        rw_n        = rw;
        ack_phase_n = ack_phase;
        sub_ptr_n   = sub_ptr;
        sda_oe_n    = sda_oe;
        busy_n      = busy;
        wr_stb_n    = 1'b0;
        wr_addr_n   = wr_addr;
        wr_data_n   = wr_data;
        mem_we      = 1'b0;

        if (start_cond) begin
            // Also covers repeated START: any partial byte is dropped.
            state_n     = S_ID;
            bit_cnt_n   = '0;
            ack_phase_n = 1'b0;
            sda_oe_n    = 1'b0;
            busy_n      = 1'b1;
        end else if (stop_cond) begin
            state_n     = S_IDLE;
            bit_cnt_n   = '0;
            ack_phase_n = 1'b0;
            sda_oe_n    = 1'b0;
            busy_n      = 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    sda_oe_n = 1'b0;
                end

                S_ID, S_SUB, S_WDATA: begin
                    if (scl_rise) begin
                        shift_n   = rx_byte[6:0];
                        bit_cnt_n = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            ack_phase_n = 1'b0;
                            if (state == S_ID) begin
                                if (rx_byte[7:1] == DEV_ID) begin
                                    state_n = S_ID_ACK;
                                    rw_n    = rx_byte[0];
                                end else begin
                                    state_n = S_IGNORE;
                                    busy_n  = 1'b0;
                                end
                            end else if (state == S_SUB) begin
                                state_n   = S_SUB_ACK;
                                sub_ptr_n = rx_byte[REG_AW-1:0];
                            end else begin
                                state_n   = S_WDATA_ACK;
                                mem_we    = 1'b1;
                                wr_stb_n  = 1'b1;
                                wr_addr_n = 8'(sub_ptr);
                                wr_data_n = rx_byte;
                            end
                        end
                    end
                end

                S_ID_ACK, S_SUB_ACK, S_WDATA_ACK: begin
                    // First fall opens the 9th bit, second fall closes it.
                    if (scl_fall) begin
                        if (!ack_phase) begin
                            ack_phase_n = 1'b1;
                            sda_oe_n    = DRIVE_ACK;
                        end else begin
                            ack_phase_n = 1'b0;
                            bit_cnt_n   = '0;
                            if (state == S_ID_ACK && rw) begin
                                state_n    = S_RDATA;
                                sda_oe_n   = ~reg_rd[7];
                                rd_shift_n = {reg_rd[6:0], 1'b0};
                            end else if (state == S_ID_ACK) begin
                                state_n  = S_SUB;
                                sda_oe_n = 1'b0;
                            end else begin
                                state_n  = S_WDATA;
                                sda_oe_n = 1'b0;
                            end
                        end
                    end
                end

                S_RDATA: begin
                    // Bit 7 went out on entry; each fall ends one bit.
                    if (scl_fall) begin
                        if (bit_cnt == 3'd7) begin
                            state_n     = S_RDATA_ACK;
                            bit_cnt_n   = '0;
                            ack_phase_n = 1'b0;
                            sda_oe_n    = 1'b0;
                        end else begin
                            bit_cnt_n  = bit_cnt + 3'd1;
                            sda_oe_n   = ~rd_shift[7];
                            rd_shift_n = {rd_shift[6:0], 1'b0};
                        end
                    end
                end

                S_RDATA_ACK: begin
                    // Master ACK re-arms the same register on the closing fall.
                    if (scl_rise) begin
                        if (sda_s) begin
                            state_n = S_IGNORE;
                        end else begin
                            ack_phase_n = 1'b1;
                        end
                    end else if (scl_fall && ack_phase) begin
                        state_n     = S_RDATA;
                        ack_phase_n = 1'b0;
                        bit_cnt_n   = '0;
                        sda_oe_n    = ~reg_rd[7];
                        rd_shift_n  = {reg_rd[6:0], 1'b0};
                    end
                end

                S_IGNORE: begin
                    sda_oe_n = 1'b0;
                end

                default: begin
                    state_n  = S_IDLE;
                    sda_oe_n = 1'b0;
                    busy_n   = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sccb_target.sv
// tb_sccb_target: directed plus randomized SCCB traffic against sccb_target.
// A transaction-level model (register array, pointer, expected-write queue)
// predicts ACKs, read data and committed writes.
module tb_sccb_target;

    logic       ila_clk = 1'b0;
    logic       n_rst   = 1'b0;
    logic       scl     = 1'b1;
    logic       sda_m   = 1'b1;
    logic       sda_oe;
    logic       wr_stb;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;
    wire        sda_bus = sda_m & ~sda_oe;

    sccb_target dut (
        .ila_clk (ila_clk),
        .n_rst   (n_rst),
        .scl_i   (scl),
        .sda_i   (sda_bus),
        .sda_oe  (sda_oe),
        .wr_stb  (wr_stb),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .busy    (busy)
    );

    always #100 ila_clk = ~ila_clk;

    int          n_assert = 0;
    int          n_fail   = 0;
    int          oe_cnt   = 0;
    logic [15:0] obs_q[$];
    logic [15:0] exp_q[$];
    logic [7:0]  ref_mem [256];
    logic [7:0]  ref_ptr;

    // Passive monitor: record committed writes and count cycles driving SDA.
    always @(negedge ila_clk) begin
        if (wr_stb === 1'b1) obs_q.push_back({wr_addr, wr_data});
        if (sda_oe === 1'b1) oe_cnt++;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic qtr();
        repeat (5) @(negedge ila_clk);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; qtr();
        scl   = 1'b1; qtr();
        sda_m = 1'b0; qtr();
        scl   = 1'b0; qtr();
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; qtr();
        scl   = 1'b1; qtr();
        sda_m = 1'b1; qtr();
    endtask

    task automatic put_bit(input logic b, output logic oe_seen);
        sda_m = b;    qtr();
        scl   = 1'b1; qtr();
        oe_seen = sda_oe;
        qtr();
        scl   = 1'b0; qtr();
    endtask

    task automatic put_byte(input logic [7:0] b, output logic ack);
        logic o;
        for (int i = 7; i >= 0; i--) put_bit(b[i], o);
        put_bit(1'b1, ack);
    endtask

    task automatic get_byte(input logic master_nack, output logic [7:0] v);
        for (int i = 7; i >= 0; i--) begin
            sda_m = 1'b1; qtr();
            scl   = 1'b1; qtr();
            v[i]  = sda_bus;
            qtr();
            scl   = 1'b0; qtr();
        end
        sda_m = master_nack; qtr();
        scl   = 1'b1; qtr(); qtr();
        scl   = 1'b0; qtr();
    endtask

    task automatic check_writes(input string tag);
        int n;
        chk({tag, "_wr_count"}, 16'(obs_q.size()), 16'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk({tag, "_wr_addr_data"}, obs_q[i], exp_q[i]);
        obs_q.delete();
        exp_q.delete();
    endtask

    // Write phase of a 3-phase write (START already optional via bus_start here).
    task automatic txn_write(input logic [7:0] addr, input logic [7:0] d0, input logic [7:0] d1,
                             input logic [7:0] d2, input int n);
        logic       ack;
        logic [7:0] d [3];
        d[0] = d0; d[1] = d1; d[2] = d2;
        bus_start();
        put_byte(8'h42, ack);
        chk("wr_id_ack", ack, 1'b1);
        chk("wr_busy", busy, 1'b1);
        put_byte(addr, ack);
        chk("wr_sub_ack", ack, 1'b1);
        ref_ptr = addr;
        for (int i = 0; i < n; i++) begin
            put_byte(d[i], ack);
            chk("wr_data_ack", ack, 1'b1);
            ref_mem[addr] = d[i];
            exp_q.push_back({addr, d[i]});
        end
        bus_stop();
        chk("wr_busy_after_stop", busy, 1'b0);
        check_writes("write");
    endtask

    task automatic txn_set_ptr(input logic [7:0] addr);
        logic ack;
        bus_start();
        put_byte(8'h42, ack);
        chk("ptr_id_ack", ack, 1'b1);
        put_byte(addr, ack);
        chk("ptr_sub_ack", ack, 1'b1);
        ref_ptr = addr;
        bus_stop();
        chk("ptr_busy_after_stop", busy, 1'b0);
    endtask

    task automatic txn_read(input int n);
        logic       ack;
        logic [7:0] v;
        bus_start();
        put_byte(8'h43, ack);
        chk("rd_id_ack", ack, 1'b1);
        chk("rd_busy", busy, 1'b1);
        for (int i = 0; i < n; i++) begin
            get_byte(i == n - 1, v);
            chk("rd_data", v, ref_mem[ref_ptr]);
        end
        bus_stop();
        chk("rd_busy_after_stop", busy, 1'b0);
        check_writes("read");
    endtask

    task automatic txn_bad(input logic [7:0] id);
        logic ack;
        int   oe_before;
        oe_before = oe_cnt;
        bus_start();
        put_byte(id, ack);
        chk("bad_id_nack", ack, 1'b0);
        chk("bad_busy", busy, 1'b0);
        put_byte(8'h12, ack);
        put_byte(8'h55, ack);
        bus_stop();
        chk("bad_no_drive", 16'(oe_cnt - oe_before), 16'd0);
        check_writes("bad");
    endtask

    initial begin
        logic       ack;
        logic       o;
        logic [7:0] b;
        int         kind;

        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        ref_ptr = 8'h00;

        // Reset state
        repeat (4) @(negedge ila_clk);
        chk("rst_sda_oe",  sda_oe,  1'b0);
        chk("rst_wr_stb",  wr_stb,  1'b0);
        chk("rst_wr_addr", wr_addr, 8'h00);
        chk("rst_wr_data", wr_data, 8'h00);
        chk("rst_busy",    busy,    1'b0);
        n_rst = 1'b1;
        repeat (4) @(negedge ila_clk);

        // 1: 3-phase write
        txn_write(8'h12, 8'h80, 8'h00, 8'h00, 1);

        // 2: read back via 2-phase write + 2-phase read, master NACK
        txn_set_ptr(8'h12);
        txn_read(1);

        // 3: wrong device ID, register untouched
        txn_bad(8'h60);
        txn_read(1);

        // 4: repeated START after 4 bits of the sub-address byte
        bus_start();
        put_byte(8'h42, ack);
        chk("rs_id_ack", ack, 1'b1);
        put_bit(1'b1, o); put_bit(1'b1, o); put_bit(1'b0, o); put_bit(1'b1, o);
        txn_write(8'h05, 8'hA5, 8'h00, 8'h00, 1);

        // 5: multi-byte write, same sub-address each time
        txn_write(8'h20, 8'h11, 8'h22, 8'h00, 2);
        txn_read(1);

        // 6: reset while the target holds the WDATA ACK
        bus_start();
        put_byte(8'h42, ack);
        put_byte(8'h20, ack);
        for (int i = 7; i >= 0; i--) begin
            b = 8'h33;
            put_bit(b[i], o);
        end
        exp_q.push_back({8'h20, 8'h33});
        sda_m = 1'b1; qtr();
        scl   = 1'b1; qtr();
        chk("rst6_ack_driven", sda_oe, 1'b1);
        n_rst = 1'b0;
        @(negedge ila_clk);
        chk("rst6_sda_released", sda_oe, 1'b0);
        chk("rst6_busy", busy, 1'b0);
        n_rst = 1'b1;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        ref_ptr = 8'h00;
        qtr();
        scl = 1'b0; qtr();
        bus_stop();
        check_writes("rst6");
        txn_set_ptr(8'h20);
        txn_read(1);

        // Randomized traffic against the model
        for (int t = 0; t < 24; t++) begin
            kind = $urandom_range(0, 3);
            case (kind)
                0: txn_write(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                             $urandom_range(1, 3));
                1: begin
                    txn_set_ptr(8'($urandom));
                    txn_read($urandom_range(1, 3));
                end
                2: txn_read($urandom_range(1, 3));
                default: begin
                    b = 8'($urandom);
                    if (b[7:1] == 7'h21) b[7] = ~b[7];
                    txn_bad(b);
                end
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
